psram_qpi_burst_ctrl: RTL

Parametrised QPI PSRAM controller for the Tang Nano PSRAM path. Runs the power-up sequence (delay, RSTEN, RST, enter-QPI) by itself, then serves single- or multi-word read/write bursts of 16-bit words through a valid/ready request port. The PSRAM pins are split into output, output-enable and input, with the tristate at top level. It replaces the fixed one-word driver and the button-started init.

---
 rtl/psram_qpi_burst_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/psram_qpi_burst_ctrl.sv
// QPI PSRAM controller: runs the power-up / QPI-enter sequence on its own, then
// serves 16-bit single- or multi-word read/write bursts through a valid/ready port.
module psram_qpi_burst_ctrl #(
  parameter int INIT_DELAY  = 12800,
  parameter int WAIT_CYCLES = 6,
  parameter int MAX_BURST   = 4,
  parameter int LEN_W       = $clog2(MAX_BURST + 1)
) (
  input  logic             mem_clk,
  input  logic             rst,
  output logic             init_done,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [22:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [15:0]      wr_data,
  output logic             wr_ready,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             mem_ce,
  output logic             mem_sck_en,
  output logic [3:0]       mem_sio_o,
  output logic [3:0]       mem_sio_oe,
  input  logic [3:0]       mem_sio_i
);
  localparam int CNT_W = $clog2(INIT_DELAY + 4 * MAX_BURST + WAIT_CYCLES + 8);
  localparam int PW    = LEN_W + 11;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_SPI_CMD, S_GAP, S_IDLE, S_REJECT,
    S_CMD, S_ADDR, S_WAIT, S_DATA
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic             init_done_q, init_done_d;
  logic             write_q, write_d;
  logic [22:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      wr_word_q, wr_word_d;
  logic [11:0]      rd_shift_q;
  logic [15:0]      rd_data_q;
  logic             rd_valid_q;

  logic [22:0]      req_addr_even;
  logic [PW-1:0]    page_end;
  logic             req_bad;
  logic [CNT_W-1:0] last_nib;
  logic [7:0]       spi_byte;
  logic [7:0]       qpi_cmd;
  logic [23:0]      addr_word;

  assign req_addr_even = req_addr & ~23'd1;
  assign page_end      = PW'(req_addr_even[9:0]) + PW'({req_len, 1'b0});
  assign req_bad       = (req_len == '0) || (req_len > LEN_W'(MAX_BURST)) ||
                         (page_end > PW'(1024));
  assign last_nib      = (CNT_W'(len_q) << 2) - CNT_W'(1);
  assign qpi_cmd       = write_q ? 8'h38 : 8'hEB;
  assign addr_word     = {1'b0, addr_q};

  assign init_done  = init_done_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign mem_sck_en = ~mem_ce;

  always_comb begin
    case (init_idx_q)
      2'd0:    spi_byte = 8'h66;
      2'd1:    spi_byte = 8'h99;
      default: spi_byte = 8'h35;
    endcase
  end

  // NOTE: every next-state value and output gets a default before the case,
  // so no path through this block can leave a latch behind.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    write_d     = write_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wr_word_d   = wr_word_q;
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    mem_ce      = 1'b1;
    mem_sio_o   = 4'h0;
    mem_sio_oe  = 4'h0;

    case (state_q)
      S_INIT_WAIT: begin
        if (cnt_q == CNT_W'(INIT_DELAY - 1)) begin
          state_d = S_SPI_CMD;
          cnt_d   = '0;
        end
      end
      S_SPI_CMD: begin
        mem_ce     = 1'b0;
        mem_sio_oe = 4'b0001;
        mem_sio_o  = {3'b000, spi_byte[~cnt_q[2:0]]};
        if (cnt_q == CNT_W'(7)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        // After a burst the IDLE cycle is the second CE-high cycle, so a
        // request held pending restarts CE exactly two cycles later.
        if (init_done_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          cnt_d = '0;
          if (init_idx_q == 2'd2) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = S_SPI_CMD;
          end
        end
      end
      S_IDLE: begin
        req_ready = init_done_q;
        cnt_d     = '0;
        if (req_valid && init_done_q) begin
          write_d   = req_write;
          addr_d    = req_addr_even;
          len_d     = req_len;
          wr_word_d = wr_data;
          state_d   = req_bad ? S_REJECT : S_CMD;
        end
      end
      S_REJECT: begin
        err     = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      S_CMD: begin
        mem_ce     = 1'b0;
        mem_sio_oe = 4'hF;
        mem_sio_o  = cnt_q[0] ? qpi_cmd[3:0] : qpi_cmd[7:4];
        if (cnt_q[0]) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        mem_ce     = 1'b0;
        mem_sio_oe = 4'hF;
        case (cnt_q[2:0])
          3'd0:    mem_sio_o = addr_word[23:20];
          3'd1:    mem_sio_o = addr_word[19:16];
          3'd2:    mem_sio_o = addr_word[15:12];
          3'd3:    mem_sio_o = addr_word[11:8];
          3'd4:    mem_sio_o = addr_word[7:4];
          default: mem_sio_o = addr_word[3:0];
        endcase
        if (cnt_q == CNT_W'(5)) begin
          cnt_d   = '0;
          state_d = (write_q || WAIT_CYCLES == 0) ? S_DATA : S_WAIT;
        end
      end
      S_WAIT: begin
        mem_ce = 1'b0;
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        mem_ce = 1'b0;
        if (write_q) begin
          mem_sio_oe = 4'hF;
          case (cnt_q[1:0])
            2'd0:    mem_sio_o = wr_word_q[15:12];
            2'd1:    mem_sio_o = wr_word_q[11:8];
            2'd2:    mem_sio_o = wr_word_q[7:4];
            default: mem_sio_o = wr_word_q[3:0];
          endcase
          if (cnt_q[1:0] == 2'd3 && cnt_q != last_nib) begin
            wr_ready  = 1'b1;
            wr_word_d = wr_data;
          end
        end
        if (cnt_q == last_nib) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      default: state_d = S_INIT_WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT_WAIT;
      cnt_q       <= '0;
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      wr_word_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wr_word_q   <= wr_word_d;
    end
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      rd_shift_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (state_q == S_DATA && !write_q) begin
      rd_shift_q <= {rd_shift_q[7:0], mem_sio_i};
      rd_valid_q <= (cnt_q[1:0] == 2'd3);
      if (cnt_q[1:0] == 2'd3) rd_data_q <= {rd_shift_q, mem_sio_i};
    end else begin
      rd_valid_q <= 1'b0;
    end
  end
endmodule
